// File: rtl/pad_owner_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// azadi_pad_arb_pkg
//   Shared types and constants for the pad ownership arbiter.
//   - arb_state_e      : arbiter phases (IDLE, GRANT, GUARD)
//   - HOLD_W           : width of the grant hold counter and hold limit
//   - GUARD_W          : width of the guard interval counter (up to 255)
//   - DEF_GUARD_CYCLES : default tristate interval between owners
//   - sel_width()      : width of an owner index for a given requester count
// ---------------------------------------------------------------------------
package azadi_pad_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } arb_state_e;

    localparam int HOLD_W           = 16;
    localparam int GUARD_W          = 8;
    localparam int DEF_GUARD_CYCLES = 4;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_owner_arbiter_if.sv
// ---------------------------------------------------------------------------
// pad_owner_arbiter_if
//   Request/grant bundle between the pad requesters and the arbiter.
//   - req_i       : per-requester ownership request (level)
//   - max_hold_i  : grant hold limit in cycles, 0 = unlimited
//   - gnt_o       : one-hot grant
//   - sel_o       : index of current or last owner (pad mux select)
//   - pad_hiz_o   : 1 forces the pad group to input
//   - busy_o      : arbiter is granting or guarding
//   - timeout_o   : one-cycle pulse on hold-limit revoke
//   Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface pad_owner_arbiter_if
    import azadi_pad_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    localparam int SEL_W = sel_width(NUM_REQ);

    logic [NUM_REQ-1:0] req_i;
    logic [HOLD_W-1:0]  max_hold_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [SEL_W-1:0]   sel_o;
    logic               pad_hiz_o;
    logic               busy_o;
    logic               timeout_o;

    modport master (
        output req_i, max_hold_i,
        input  gnt_o, sel_o, pad_hiz_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i, max_hold_i,
        output gnt_o, sel_o, pad_hiz_o, busy_o, timeout_o
    );

endinterface

// File: rtl/pad_owner_arbiter_pick.sv
// ---------------------------------------------------------------------------
// pad_arb_pick
//   Combinational winner select among eligible requesters.
//   - eligible_i : requesters allowed to win this cycle
//   - ptr_i      : round-robin start index (ignored in fixed priority)
//   - valid_o    : at least one requester is eligible
//   - idx_o      : index of the winner
//   Build option PAD_ARB_RR_EN: defined = round-robin search starting at
//   ptr_i and wrapping; undefined = fixed priority, lowest index wins.
// ---------------------------------------------------------------------------
module pad_arb_pick
    import azadi_pad_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]            eligible_i,
    input  logic [sel_width(NUM_REQ)-1:0] ptr_i,
    output logic                          valid_o,
    output logic [sel_width(NUM_REQ)-1:0] idx_o
);

    localparam int SEL_W = sel_width(NUM_REQ);
    localparam int SUM_W = SEL_W + 1;

`ifdef PAD_ARB_RR_EN
    logic [SUM_W-1:0] sum;
    logic [SEL_W-1:0] cand;

    // Walk offsets from far to near so the closest eligible index after
    // ptr_i is the last one written and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_i} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            cand = sum[SEL_W-1:0];
            if (eligible_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Highest index first so the lowest eligible index wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                valid_o = 1'b1;
                idx_o   = SEL_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/pad_owner_arbiter.sv
// ---------------------------------------------------------------------------
// pad_owner_arbiter
//   Exclusive ownership arbiter for a shared IO pad group. Grants one owner
//   at a time, inserts a tristate guard interval on every ownership change
//   and can revoke a grant after a programmable hold limit.
//   Ports:
//   - wb_clk_i : system clock, rising edge
//   - wb_rst_i : asynchronous active-high reset
//   - bus      : pad_owner_arbiter_if.slave (req_i, max_hold_i in;
//                gnt_o, sel_o, pad_hiz_o, busy_o, timeout_o out)
//   Parameters: NUM_REQ (2..8), GUARD_CYCLES (1..255).
//   Build option PAD_ARB_RR_EN: round-robin arbitration with a rotating
//   pointer; without it, fixed priority (lowest index wins).
//   All outputs are registered.
// ---------------------------------------------------------------------------
module pad_owner_arbiter
    import azadi_pad_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    pad_owner_arbiter_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_GRANT = GRANT;
    localparam logic [1:0] ST_GUARD = GUARD;

    localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES);

    logic [1:0]         state_q,   state_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic               hiz_q,     hiz_d;
    logic               busy_q,    busy_d;
    logic               timeout_q, timeout_d;
    logic [HOLD_W-1:0]  hold_q,    hold_d;
    logic [GUARD_W-1:0] guard_q,   guard_d;
    logic [NUM_REQ-1:0] mask_q,    mask_d;

    logic [NUM_REQ-1:0] eligible;
    logic [SEL_W-1:0]   pick_ptr;
    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic               grant_now;

    // A revoked requester stays out of arbitration until it drops its request.
    assign eligible = bus.req_i & ~mask_q;

`ifdef PAD_ARB_RR_EN
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

    logic [SEL_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_now) begin
            ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_ptr = ptr_q;
`else
    assign pick_ptr = '0;
`endif

    pad_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (pick_ptr),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    // Release is checked before the hold limit so a same-cycle release and
    // limit hit is a plain release: no timeout pulse, no mask.
    // A winner can be taken both from IDLE and at the end of GUARD; both
    // paths share the grant assignments after the case.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        hiz_d     = hiz_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        guard_d   = guard_q;
        mask_d    = mask_q & bus.req_i;
        grant_now = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_now = pick_valid;
            end
            ST_GRANT: begin
                if (!bus.req_i[sel_q]) begin
                    state_d = ST_GUARD;
                    gnt_d   = '0;
                    hiz_d   = 1'b1;
                    guard_d = GUARD_INIT;
                end else if ((bus.max_hold_i != '0) && (hold_q >= bus.max_hold_i)) begin
                    state_d       = ST_GUARD;
                    gnt_d         = '0;
                    hiz_d         = 1'b1;
                    guard_d       = GUARD_INIT;
                    timeout_d     = 1'b1;
                    mask_d[sel_q] = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_GUARD: begin
                if (guard_q == GUARD_W'(1)) begin
                    if (pick_valid) begin
                        grant_now = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    guard_d = guard_q - GUARD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                hiz_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (grant_now) begin
            state_d = ST_GRANT;
            gnt_d   = NUM_REQ'(1) << pick_idx;
            sel_d   = pick_idx;
            hiz_d   = 1'b0;
            busy_d  = 1'b1;
            hold_d  = HOLD_W'(1);
        end
    end

    // Reset tristates the pads immediately, without waiting for a clock.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            hiz_q     <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            guard_q   <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            hiz_q     <= hiz_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            guard_q   <= guard_d;
            mask_q    <= mask_d;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.sel_o     = sel_q;
    assign bus.pad_hiz_o = hiz_q;
    assign bus.busy_o    = busy_q;
    assign bus.timeout_o = timeout_q;

endmodule

// File: doc/pad_owner_arbiter.md
# pad_owner_arbiter

Sequential ownership arbiter for a shared IO pad group in the azadi SoC Caravel wrapper. Up to NUM_REQ peripherals (GPIO, SPI slave-selects, PWM, JTAG) request exclusive use of the same pads. The block grants one owner at a time with a req/gnt handshake and enforces a tristate guard interval on every ownership change. It can revoke a grant after a programmable hold limit. Its outputs drive the wrapper's pad mux select and force io_oeb high during idle and guard periods.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- GUARD_CYCLES, 4: tristate cycles between owners; legal range 1..255.
- wb_clk_i  input  1  system clock; all state updates on the rising edge.
- wb_rst_i  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester ownership request; level, held for the whole tenure.
- max_hold_i  input  16  grant hold limit in cycles; 0 means unlimited; sampled live every cycle.
- gnt_o  output  NUM_REQ  one-hot grant; all zero when no owner.
- sel_o  output  $clog2(NUM_REQ)  index of the current or last owner; pad mux select.
- pad_hiz_o  output  1  1 forces all pads in the group to input (io_oeb=1).
- busy_o  output  1  1 in GRANT or GUARD.
- timeout_o  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values: state IDLE, gnt_o=0, sel_o=0, pad_hiz_o=1, busy_o=0, timeout_o=0, rr pointer=0, hold_cnt=0, guard_cnt=0, revoke mask=0.
- Eligible requesters: req_i & ~mask. A mask bit sets on revoke. It clears on the first cycle its req_i is sampled low.
- IDLE:
  - If any requester is eligible, pick the winner and go to GRANT.
  - Registered outputs: gnt_o[w]=1, sel_o=w, pad_hiz_o=0, busy_o=1.
  - hold_cnt=1.
- GRANT:
  - hold_cnt increments each cycle and saturates at 16'hFFFF.
  - If req_i[owner]=0, go to GUARD: gnt_o=0, pad_hiz_o=1, guard_cnt=GUARD_CYCLES.
  - Else if max_hold_i!=0 and hold_cnt>=max_hold_i, go to GUARD with the same outputs, plus timeout_o=1 for one cycle and mask[owner]=1.
  - If release and limit happen in the same cycle, treat it as a release: no timeout pulse, no mask.
  - Requests from other requesters do not preempt the owner.
- GUARD:
  - guard_cnt decrements each cycle. sel_o holds the old owner.
  - When guard_cnt reaches 1, arbitrate among eligible requesters. Go to GRANT if there is a winner, else go to IDLE with busy_o=0.
- Arbitration (the choice is between round-robin and fixed priority; see Configuration):
  - In round-robin mode, search from index ptr upward, wrapping modulo NUM_REQ. After granting w, ptr=(w+1) mod NUM_REQ.
- An owner dropping and re-raising req_i during GUARD competes as a normal requester.
- Reset asserted mid-grant or mid-guard: immediate return to reset values. pad_hiz_o goes to 1 without waiting for a clock.

## Timing
- Request to grant from IDLE: req_i high before edge n gives gnt_o high after edge n. That is one cycle of latency.
- Release to pad tristate: req_i low before edge n gives gnt_o=0 and pad_hiz_o=1 after edge n.
- Owner-to-owner gap: exactly GUARD_CYCLES cycles with gnt_o=0 and pad_hiz_o=1.
- gnt_o and pad_hiz_o change on the same edge. pad_hiz_o is never 0 while gnt_o is 0.
- Timeout: with max_hold_i=M, gnt_o stays high for exactly M cycles.
- timeout_o is high during the first GUARD cycle only.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- PAD_ARB_RR_EN:
  - Defined: round-robin arbitration with the ptr register described above.
  - Undefined: fixed priority, lowest index wins. ptr is not implemented, and timeout masking remains the only fairness mechanism.

## Structure
- Package azadi_pad_arb_pkg holds:
  - arb_state_e enum: IDLE, GRANT, GUARD.
  - HOLD_W=16.
  - Default GUARD_CYCLES constant.
- Sub-module pad_arb_pick: combinational winner select.
  - Inputs: eligible vector, ptr.
  - Outputs: valid, index.
  - Compiled as round-robin or fixed priority under PAD_ARB_RR_EN.

## Test plan
- Reset with req_i=4'b1111: after reset release, gnt_o=4'b0001 one cycle later, pad_hiz_o=0, sel_o=0.
- Owner 0 drops req with req_i[2]=1 and GUARD_CYCLES=4: exactly 4 cycles of gnt_o=0 and pad_hiz_o=1, then gnt_o=4'b0100, sel_o=2.
- Round-robin (PAD_ARB_RR_EN defined), all four requesting, each releasing after 3 cycles: grant order 0,1,2,3,0. Without the macro the order is 0,0,0 for as long as req_i[0] re-asserts.
- max_hold_i=10 with requester 1 holding forever: gnt_o[1] high for 10 cycles, then timeout_o pulses once. Requester 1 is not re-granted until req_i[1] goes low for at least one cycle.
- Same-cycle release and hold limit (max_hold_i=5, req_i[1] drops in cycle 5): GUARD entered, timeout_o stays 0, mask stays clear.
- wb_rst_i asserted asynchronously mid-GRANT: gnt_o=0 and pad_hiz_o=1 immediately, without waiting for a clock. Normal operation resumes one cycle after deassertion.
